chess_scan_sequencer: RTL
=========================

# chess_scan_sequencer

Scan controller for the 8x8 reed-switch/Hall sensor matrix of the chess board. It sequences the external row decoder: address, enable, settle time, column sampling and break-before-make between rows. It debounces each of the 64 squares across whole frames and publishes a stable occupancy map with per-frame change events. It replaces free-running scanning as the sole owner of the row-decoder pins and feeds the piece-value and move-detection logic downstream.

## Interface
- SETTLE_CYCLES, 1000: cycles a row is driven before columns are sampled (10 µs at 100 MHz); legal range ≥1.
- DEBOUNCE_SCANS, 3: consecutive frames a square must disagree with its stable value before the stable value flips; legal range ≥1.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  1 = scan continuously; 0 = stop at the next frame boundary.
- col_in  in  8  column sense lines, active-low (0 = piece present).
- row_addr  out  3  row address to the external 3:8 decoder.
- row_addr_en  out  1  decoder enable, active-low.
- sensor_state  out  64  debounced occupancy; bit row*8+col, 1 = piece present.
- changed_mask  out  64  bits of sensor_state that flipped at the last frame end.
- change  out  1  one-cycle pulse when changed_mask is non-zero.
- frame_done  out  1  one-cycle pulse per completed frame.
- busy  out  1  1 whenever state ≠ IDLE.

## Operation
- States: IDLE, DRIVE, SAMPLE, BLANK, FRAME_END.
- IDLE:
  - row_addr_en=1, row=0.
  - enable=1 → DRIVE, settle counter=0.
- DRIVE:
  - row_addr=row, row_addr_en=0, counter increments.
  - When counter = SETTLE_CYCLES-1 → SAMPLE.
- SAMPLE:
  - row_addr_en stays 0.
  - raw[row*8+c] <= ~col_in[c] for c=0..7.
  - → BLANK.
- BLANK:
  - row_addr_en=1, row_addr holds.
  - row=7 → FRAME_END; otherwise row++ → DRIVE, counter cleared.
- FRAME_END, per square:
  - If raw == stable, the debounce count clears.
  - Otherwise the count increments. When it reaches DEBOUNCE_SCANS, stable flips, the count clears and the changed bit is set.
  - Count width is clog2(DEBOUNCE_SCANS+1); the count saturates and never wraps.
  - Next state: enable=1 → DRIVE (row 0); enable=0 → IDLE.
- enable falling mid-frame: the current frame completes through FRAME_END, then the block goes IDLE. A partial frame never updates sensor_state.
- enable rising while IDLE restarts at row 0. Debounce counters persist across IDLE periods.
- Reset, including mid-frame: state=IDLE, row=0, all raw/stable/count registers=0.

## Timing
- Reset values: row_addr=0, row_addr_en=1, sensor_state=0, changed_mask=0, change=0, frame_done=0, busy=0.
- All outputs are registered; row_addr/row_addr_en change only on clk edges, glitch-free.
- Per row: SETTLE_CYCLES DRIVE + 1 SAMPLE + 1 BLANK = SETTLE_CYCLES+2 cycles.
  - row_addr_en is low for SETTLE_CYCLES+1 cycles and high for ≥1 cycle between rows.
- Frame length: 8·(SETTLE_CYCLES+2)+1 cycles (continuous mode).
- sensor_state, changed_mask, frame_done and change all update in the cycle after FRAME_END, together.
- changed_mask holds until the next frame end. frame_done and change are high for exactly one cycle.
- IDLE → first DRIVE: 1 cycle after enable is sampled high.

## Structure
- Shared package chess_scan_pkg holds:
  - NUM_ROWS=8, NUM_COLS=8, NUM_SQUARES=64
  - the scan state enum
  - the square index function row*8+col
- Sub-module square_debouncer (parameter DEBOUNCE_SCANS): inputs clk, rst, update, raw; outputs stable, flipped. Instantiated 64× via generate.
- The top level holds the FSM, settle counter, row counter and raw frame register.

## Test plan
All scenarios use SETTLE_CYCLES=4, DEBOUNCE_SCANS=3; frame = 49 cycles.
- Reset, enable=1, col_in=8'hFF constant:
  - row_addr steps 0..7.
  - row_addr_en low 5 cycles, high 1 cycle per row.
  - frame_done every 49 cycles.
  - sensor_state stays 0, change never pulses.
- col_in=8'hFE while row_addr=3, every frame:
  - No change after frames 1–2.
  - After frame 3: sensor_state=64'h0000_0000_0100_0000, changed_mask equal, change=1 for one cycle.
- Same stimulus for only 2 frames, then col_in=8'hFF: sensor_state stays 0, no change pulse, debounce count back to 0.
- col_in=8'h00 on rows 0,1,6,7, 8'hFF elsewhere: after frame 3, sensor_state=64'hFFFF_0000_0000_FFFF and changed_mask equal.
- enable dropped during row 4:
  - Rows 5–7 still scanned, frame_done pulses.
  - Then IDLE: busy=0, row_addr_en=1, row_addr=0.
- rst pulsed during row 5 DRIVE with 2 frames of debounce history:
  - All outputs go to reset values immediately.
  - After release, scanning restarts at row 0 and a held piece needs 3 full frames to appear.

Source files
------------

// File: rtl/chess_scan_pkg.sv
// -----------------------------------------------------------------------------
// chess_scan_pkg
// Shared definitions for the chess board sensor-matrix scanner:
//   - board geometry (rows, columns, squares) and index widths
//   - scan FSM state encoding
//   - sq_index(): flat square index row*8+col used for the occupancy maps
// -----------------------------------------------------------------------------
package chess_scan_pkg;

    localparam int NUM_ROWS    = 8;
    localparam int NUM_COLS    = 8;
    localparam int NUM_SQUARES = NUM_ROWS * NUM_COLS;

    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam int COL_W = $clog2(NUM_COLS);
    localparam int SQ_W  = $clog2(NUM_SQUARES);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DRIVE     = 3'd1,
        ST_SAMPLE    = 3'd2,
        ST_BLANK     = 3'd3,
        ST_FRAME_END = 3'd4
    } scan_state_t;

    // With 8 columns, row*8+col is a plain concatenation of the two fields.
    function automatic logic [SQ_W-1:0] sq_index(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/chess_scan_sequencer_if.sv
// -----------------------------------------------------------------------------
// chess_scan_sequencer_if
// Bundles the scanner's board-side and downstream-side signals.
//   enable        host -> scanner   1 = scan continuously, 0 = stop at frame end
//   col_in[7:0]   board -> scanner  column sense lines, active-low
//   row_addr[2:0] scanner -> board  row address to the 3:8 decoder
//   row_addr_en   scanner -> board  decoder enable, active-low
//   sensor_state  scanner -> logic  debounced occupancy, bit row*8+col
//   changed_mask  scanner -> logic  squares that flipped at the last frame end
//   change        scanner -> logic  one-cycle pulse, changed_mask non-zero
//   frame_done    scanner -> logic  one-cycle pulse per completed frame
//   busy          scanner -> logic  scanner not idle
// master = the side driving enable/col_in; slave = the scanner itself.
// -----------------------------------------------------------------------------
interface chess_scan_sequencer_if;
    import chess_scan_pkg::*;

    logic                   enable;
    logic [NUM_COLS-1:0]    col_in;
    logic [ROW_W-1:0]       row_addr;
    logic                   row_addr_en;
    logic [NUM_SQUARES-1:0] sensor_state;
    logic [NUM_SQUARES-1:0] changed_mask;
    logic                   change;
    logic                   frame_done;
    logic                   busy;

    modport master (
        output enable,
        output col_in,
        input  row_addr,
        input  row_addr_en,
        input  sensor_state,
        input  changed_mask,
        input  change,
        input  frame_done,
        input  busy
    );

    modport slave (
        input  enable,
        input  col_in,
        output row_addr,
        output row_addr_en,
        output sensor_state,
        output changed_mask,
        output change,
        output frame_done,
        output busy
    );

endinterface

// File: rtl/chess_scan_sequencer_debouncer.sv
// -----------------------------------------------------------------------------
// square_debouncer
// Frame-rate debouncer for one board square. On every i_update pulse (one per
// completed frame) the latest raw sample is compared with the stable value; the
// stable value flips only after DEBOUNCE_SCANS consecutive disagreeing frames.
//   clk, rst     clock, asynchronous active-high reset
//   i_update     one-cycle pulse at frame end
//   i_raw        raw occupancy sampled during the frame (1 = piece)
//   o_stable     debounced occupancy
//   o_flipped    o_stable flipped at the last update; held until the next one
//   o_flip_next  combinational: this update will flip o_stable, so the parent
//                can register a change pulse aligned with o_flipped
// -----------------------------------------------------------------------------
module square_debouncer
    import chess_scan_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_update,
    input  logic i_raw,
    output logic o_stable,
    output logic o_flipped,
    output logic o_flip_next
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

    logic [CNT_W-1:0] r_count;
    logic             r_stable;
    logic             r_flipped;

    logic             w_differs;
    logic             w_flip;
    logic [CNT_W-1:0] w_count_next;

    assign w_differs = (i_raw != r_stable);
    // This disagreeing frame is the DEBOUNCE_SCANS-th in a row.
    assign w_flip    = w_differs && (r_count >= CNT_LAST);

    always_comb begin
        w_count_next = r_count;
        if (!w_differs || w_flip) begin
            w_count_next = '0;
        end else if (r_count != CNT_MAX) begin
            w_count_next = r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_stable  <= 1'b0;
            r_flipped <= 1'b0;
        end else if (i_update) begin
            r_count   <= w_count_next;
            r_stable  <= r_stable ^ w_flip;
            r_flipped <= w_flip;
        end
    end

    assign o_stable    = r_stable;
    assign o_flipped   = r_flipped;
    assign o_flip_next = i_update && w_flip;

endmodule

// File: rtl/chess_scan_sequencer.sv
// -----------------------------------------------------------------------------
// chess_scan_sequencer
// Sole owner of the chess board row decoder. Each row is driven for
// SETTLE_CYCLES, its columns are sampled once, then the decoder is disabled
// for one cycle (break-before-make) before the next row. After row 7 a single
// FRAME_END cycle hands the raw frame to 64 square debouncers, which publish
// sensor_state / changed_mask together with frame_done and change one cycle
// later.
//   clk            system clock
//   rst            asynchronous, active-high reset
//   bus (slave)    enable, col_in in; row_addr, row_addr_en, sensor_state,
//                  changed_mask, change, frame_done, busy out
// Parameters:
//   SETTLE_CYCLES  cycles a row is driven before sampling (>=1)
//   DEBOUNCE_SCANS consecutive disagreeing frames before a square flips (>=1)
// -----------------------------------------------------------------------------
module chess_scan_sequencer
    import chess_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int DEBOUNCE_SCANS = 3
) (
    input logic                   clk,
    input logic                   rst,
    chess_scan_sequencer_if.slave bus
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [ROW_W-1:0]    LAST_ROW    = ROW_W'(NUM_ROWS - 1);

    scan_state_t            r_state;
    scan_state_t            w_next_state;
    logic [SETTLE_W-1:0]    r_settle;
    logic [SETTLE_W-1:0]    w_settle_next;
    logic [ROW_W-1:0]       r_row;
    logic [ROW_W-1:0]       w_row_next;
    logic                   r_row_addr_en;
    logic                   w_row_addr_en_next;
    logic                   r_busy;
    logic                   w_busy_next;
    logic [NUM_SQUARES-1:0] r_raw;

    logic                   w_update;
    logic [NUM_SQUARES-1:0] w_stable;
    logic [NUM_SQUARES-1:0] w_flipped;
    logic [NUM_SQUARES-1:0] w_flip_next;

    logic                   r_frame_done_p1;
    logic                   r_change_p1;

    // Scan FSM: next state plus the decoder controls it implies. The decoder
    // outputs are registered from the next state so they line up exactly with
    // the state and come straight off flops.
    always_comb begin
        w_next_state  = r_state;
        w_settle_next = r_settle;
        w_row_next    = r_row;

        unique case (r_state)
            ST_IDLE: begin
                w_row_next    = '0;
                w_settle_next = '0;
                if (bus.enable) begin
                    w_next_state = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (r_settle == SETTLE_LAST) begin
                    w_next_state = ST_SAMPLE;
                end else begin
                    w_settle_next = r_settle + 1'b1;
                end
            end
            ST_SAMPLE: begin
                w_next_state = ST_BLANK;
            end
            ST_BLANK: begin
                w_settle_next = '0;
                if (r_row == LAST_ROW) begin
                    w_next_state = ST_FRAME_END;
                    w_row_next   = '0;
                end else begin
                    w_next_state = ST_DRIVE;
                    w_row_next   = r_row + 1'b1;
                end
            end
            ST_FRAME_END: begin
                w_settle_next = '0;
                w_row_next    = '0;
                // enable only matters here: a frame in flight always completes.
                w_next_state  = bus.enable ? ST_DRIVE : ST_IDLE;
            end
            default: begin
                w_next_state  = ST_IDLE;
                w_settle_next = '0;
                w_row_next    = '0;
            end
        endcase

        w_row_addr_en_next = !((w_next_state == ST_DRIVE) ||
                               (w_next_state == ST_SAMPLE));
        w_busy_next        = (w_next_state != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_settle      <= '0;
            r_row         <= '0;
            r_row_addr_en <= 1'b1;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_settle      <= w_settle_next;
            r_row         <= w_row_next;
            r_row_addr_en <= w_row_addr_en_next;
            r_busy        <= w_busy_next;
        end
    end

    // Raw frame capture: sense lines are active-low, occupancy is active-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_raw <= '0;
        end else if (r_state == ST_SAMPLE) begin
            r_raw[sq_index(r_row, COL_W'(0)) +: NUM_COLS] <= ~bus.col_in;
        end
    end

    // ---- frame-end stage: per-square debounce ----
    assign w_update = (r_state == ST_FRAME_END);

    for (genvar g = 0; g < NUM_SQUARES; g++) begin : g_square
        square_debouncer #(
            .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
        ) u_square_debouncer (
            .clk         (clk),
            .rst         (rst),
            .i_update    (w_update),
            .i_raw       (r_raw[g]),
            .o_stable    (w_stable[g]),
            .o_flipped   (w_flipped[g]),
            .o_flip_next (w_flip_next[g])
        );
    end

    // ---- p1: cycle after FRAME_END, all published outputs update together ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_done_p1 <= 1'b0;
            r_change_p1     <= 1'b0;
        end else begin
            r_frame_done_p1 <= w_update;
            r_change_p1     <= |w_flip_next;
        end
    end

    assign bus.row_addr     = r_row;
    assign bus.row_addr_en  = r_row_addr_en;
    assign bus.sensor_state = w_stable;
    assign bus.changed_mask = w_flipped;
    assign bus.change       = r_change_p1;
    assign bus.frame_done   = r_frame_done_p1;
    assign bus.busy         = r_busy;

endmodule
